// File: rtl/srl_delay_bus_pkg.sv
// Shared types and helpers for the variable-depth parallel delay line.
// Fill-state encodings are fixed so software and waveforms can decode them directly.
package srl_delay_bus_pkg;

    typedef enum logic [1:0] {
        FillEmpty   = 2'd0,
        FillFilling = 2'd1,
        FillFull    = 2'd2
    } fill_state_e;

    // Index width for an n-entry array, never narrower than one bit.
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/srl_fill_ctrl.sv
// Fill tracking for the delay line: saturating shift counter and EMPTY/FILLING/FULL state.
// The state machine and the counter share one clocked process so they can never disagree.
module srl_fill_ctrl
    import srl_delay_bus_pkg::*;
#(
    parameter int unsigned Depth    = 256,
    parameter int unsigned CntWidth = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ce_i,
    input  logic                flush_i,
    output logic [CntWidth-1:0] fill_cnt_o,
    output logic                full_o
);

    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(Depth - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    fill_state_e         state_q;
    logic                full_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != DepthCnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // flush outranks ce, so a simultaneous shift is dropped entirely.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            state_q <= FillEmpty;
            full_q  <= 1'b0;
        end else if (flush_i) begin
            cnt_q   <= '0;
            state_q <= FillEmpty;
            full_q  <= 1'b0;
        end else if (ce_i) begin
            cnt_q <= cnt_d;
            unique case (state_q)
                FillEmpty, FillFilling: begin
                    if (cnt_q == LastCnt) begin
                        state_q <= FillFull;
                        full_q  <= 1'b1;
                    end else begin
                        state_q <= FillFilling;
                        full_q  <= 1'b0;
                    end
                end
                FillFull: begin
                    state_q <= FillFull;
                    full_q  <= 1'b1;
                end
                default: begin
                    state_q <= FillEmpty;
                    full_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fill_cnt_o = cnt_q;
    assign full_o     = full_q;

endmodule

// File: rtl/srl_delay_bus.sv
// WIDTH-bit variable-depth delay line with clock enable, synchronous flush and a qualified tap.
// q_valid only asserts when the selected tap holds data written since the last reset or flush.
module srl_delay_bus
    import srl_delay_bus_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADR_WIDTH = 8,
    parameter int unsigned SRL_DEPTH = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 flush,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic                 adr_err,
    output logic                 full,
    output logic [ADR_WIDTH:0]   fill_cnt
);

    localparam int unsigned CntW = ADR_WIDTH + 1;
    localparam int unsigned IdxW = clog2_w(SRL_DEPTH);
    localparam logic [CntW-1:0] DepthCnt = CntW'(SRL_DEPTH);

    logic            adr_ok;
    logic [IdxW-1:0] tap_idx;

    assign adr_ok  = ({1'b0, adr} < DepthCnt);
    assign tap_idx = adr[IdxW-1:0];
    assign adr_err = ~adr_ok;

    srl_fill_ctrl #(
        .Depth    (SRL_DEPTH),
        .CntWidth (CntW)
    ) u_fill_ctrl (
        .clk_i      (clock),
        .rst_i      (reset),
        .ce_i       (ce),
        .flush_i    (flush),
        .fill_cnt_o (fill_cnt),
        .full_o     (full)
    );

    // One shift register per data bit; stage 0 is the youngest sample.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [SRL_DEPTH-1:0] sr_q, sr_d;

        always_comb begin
            sr_d = sr_q;
            if (flush) begin
                sr_d = '0;
            end else if (ce) begin
                sr_d = {sr_q[SRL_DEPTH-2:0], d[b]};
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        assign q[b] = adr_ok & sr_q[tap_idx];
    end

    // Combinational so a tap change is re-qualified in the same cycle.
    assign q_valid = adr_ok & (fill_cnt > {1'b0, adr});

endmodule

// File: doc/srl_delay_bus.md
Name: srl_delay_bus

Overview:
- Variable-depth, WIDTH-bit parallel delay line with clock enable, synchronous flush and fill tracking.
- Successor to the single-bit tap shifter. Adds bus width, reset, a fill-state machine and a qualified output (q_valid) so downstream logic never consumes stale or never-written taps.
- Used for run-time-adjustable CLCT/ALCT/trigger alignment delays, where depth is set from a VME register.

Parameters:
- WIDTH, 8, data bits per stage.
- ADR_WIDTH, 8, tap-select address width.
- SRL_DEPTH, 256, number of stages. Must satisfy 2 <= SRL_DEPTH <= 2**ADR_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ce  in  1  shift enable; the line advances only when ce=1.
- flush  in  1  synchronous clear of contents and fill state.
- adr  in  ADR_WIDTH  tap select; delay = adr+1 enabled shifts.
- d  in  WIDTH  data in.
- q  out  WIDTH  selected tap, combinational from stage registers.
- q_valid  out  1  selected tap holds data written since the last reset/flush.
- adr_err  out  1  adr >= SRL_DEPTH.
- full  out  1  all SRL_DEPTH stages written since the last reset/flush.
- fill_cnt  out  ADR_WIDTH+1  enabled shifts since flush, saturating at SRL_DEPTH.

Behaviour:
- Reset (async, any time including mid-fill):
  - all stages = 0, fill_cnt = 0, state = EMPTY.
  - outputs: q=0, q_valid=0, full=0, adr_err follows adr combinationally.
- Shift: on a rising edge with ce=1 and flush=0:
  - stage[0] <= d; stage[i] <= stage[i-1].
  - fill_cnt <= min(fill_cnt+1, SRL_DEPTH).
- ce=0: stages and fill_cnt hold.
- flush=1 (priority over ce):
  - all stages <= 0, fill_cnt <= 0, state <= EMPTY.
  - the d presented on that edge is discarded.
- q = stage[adr] when adr < SRL_DEPTH, else q = 0 and adr_err = 1.
- Latency: with ce held high, d sampled on edge N appears on q after edge N+adr. adr=0 gives 1 clock.
- q_valid = (adr < SRL_DEPTH) and (fill_cnt > adr). Combinational, so an adr change re-qualifies in the same cycle.
  - Raising adr above fill_cnt-1 drops q_valid until enough shifts occur.
  - Lowering adr keeps q_valid=1 once filled.
- Fill state machine (registered state):
  - EMPTY: fill_cnt=0. Goes to FILLING on an enabled shift.
  - FILLING: 0 < fill_cnt < SRL_DEPTH. Goes to FULL on the enabled shift that makes fill_cnt = SRL_DEPTH.
  - FULL: fill_cnt saturated; remains here while shifting.
  - Any state: flush or reset returns to EMPTY.
- full = (state == FULL).
- fill_cnt never wraps; it saturates at SRL_DEPTH.
- Simultaneous ce and flush: flush wins, as above.
- Clearing contents on flush is required, not optional: q must read 0 on invalid taps.

Decomposition:
- Shared package/header: fill-state encodings (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2) and a clog2-style width macro.
- Natural sub-module: srl_fill_ctrl, which holds the fill counter, the state machine and the full flag.
- Data stages and tap mux stay in the top module as a generate over WIDTH.

Test Plan:
- Reset mid-fill: WIDTH=8, SRL_DEPTH=16, adr=3, ce=1, d=8'hA5 for 10 clocks, then assert reset for 1 clock -> q=0, q_valid=0, fill_cnt=0, full=0 immediately, without waiting for a clock edge.
- Latency: reset, ce=1, adr=3, d = clock index 1,2,3,... -> q_valid rises after the 4th edge, q=1 at that point, and q tracks d delayed by 4 thereafter.
- Fill/saturate: SRL_DEPTH=16, ce=1 for 20 clocks -> fill_cnt goes 1..16 then holds at 16; full asserts on the 16th edge.
- ce gating: fill with adr=2, then ce=0 for 5 clocks while d toggles -> q, fill_cnt and q_valid are unchanged.
- Flush with ce: full line, then flush=1 with ce=1 and d=8'hFF -> next cycle q=0, q_valid=0, fill_cnt=0, state EMPTY.
- Address range and re-qualify: fill_cnt=5; set adr=4 -> q_valid=1; set adr=7 -> q_valid=0 until 3 more enabled shifts; set adr=16 -> adr_err=1, q=0, q_valid=0.
